// File: rtl/ps2_host_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_host_fifo                                                |
// | Description : PS/2 host with filtered clock, RX byte FIFO, command send    |
// |               with ACK check, frame timeout and sticky error flags.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_host_fifo #(
  parameter int FIFO_DEPTH     = 256,
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        chipselect,
  input  logic [3:0]  byteenable,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest_n,
  output logic        irq,
  input  logic        PS2_CLK_i,
  input  logic        PS2_DAT_i,
  output logic        PS2_CLK_o,
  output logic        PS2_DAT_o,
  output logic        PS2_CLK_t,
  output logic        PS2_DAT_t
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_FW = $clog2(FILTER_LEN + 1);
  localparam int c_IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FW-1:0] c_FLT_LAST = c_FW'(FILTER_LEN - 1);
  localparam logic [c_IW-1:0] c_INH_LAST = c_IW'(INHIBIT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(TIMEOUT_CYCLES);
  localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_INH, T_REQ, T_BITS, T_ACK, T_WAIT} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_filt, r_fall;
  logic [c_FW-1:0] r_flt_cnt;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0] r_count;
  logic [2:0] r_rx_cnt;
  logic [7:0] r_rx_shift;
  logic r_rx_par;
  logic [c_TW-1:0] r_to_cnt;
  logic [c_IW-1:0] r_inh_cnt;
  logic [9:0] r_tx_sh;
  logic [3:0] r_tx_cnt;
  logic r_clk_t, r_dat_t, r_tx_done;
  logic r_re, r_perr, r_ovf, r_txerr, r_irq;

  logic w_access, w_sel_ctrl, w_ctrl_wr, w_data_wr, w_tx_start;
  logic w_empty, w_full, w_pop, w_do_push, w_set_ovf;
  logic w_rx_push, w_rx_perr, w_tx_err, w_tx_active, w_to_busy, w_timeout;
  logic w_unused;

  assign w_unused = &{1'b0, byteenable, paddr[31:3], paddr[1:0], writedata[31:11], writedata[8:2]};

  assign PS2_CLK_o = 1'b0;
  assign PS2_DAT_o = 1'b0;
  assign PS2_CLK_t = r_clk_t;
  assign PS2_DAT_t = r_dat_t;
  assign irq       = r_irq;

  // Bus decode
  assign w_access      = psel & chipselect;
  assign w_sel_ctrl    = paddr[2];
  assign w_ctrl_wr     = w_access & write & w_sel_ctrl;
  assign w_data_wr     = w_access & write & ~w_sel_ctrl;
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_DEPTH);
  assign w_pop         = w_access & ~write & ~w_sel_ctrl & ~w_empty;
  assign w_tx_start    = w_data_wr & (r_tx_state == T_IDLE) & ~r_tx_done;
  assign waitrequest_n = w_access & (~write | w_sel_ctrl | r_tx_done);

  always_comb begin
    readdata = 32'h0;
    if (w_access && !write) begin
      if (w_sel_ctrl)
        readdata = {21'b0, r_txerr, r_ovf, ~w_empty, 6'b0, r_perr, r_re};
      else
        readdata = {16'(r_count), ~w_empty, 7'b0, w_empty ? 8'h00 : r_mem[r_rd_ptr]};
    end
  end

  // Pin synchronisers and PS2_CLK glitch filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_flt_cnt  <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= PS2_CLK_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DAT_i;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_FLT_LAST) begin
        r_clk_filt <= r_clk_s2;
        r_flt_cnt  <= '0;
        r_fall     <= ~r_clk_s2;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  // Inter-edge watchdog, shared by both directions
  assign w_tx_active = (r_tx_state != T_IDLE) && (r_tx_state != T_INH);
  assign w_to_busy   = (r_rx_state != R_IDLE) || w_tx_active;
  assign w_timeout   = w_to_busy && (r_to_cnt == c_TO_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_to_cnt <= '0;
    else if (!w_to_busy || r_fall)
      r_to_cnt <= '0;
    else if (r_to_cnt != c_TO_MAX)
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  // RX FSM; a send in progress discards any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= R_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    w_rx_perr = 1'b0;
    if (r_tx_state != T_IDLE || w_timeout) begin
      w_rx_next = R_IDLE;
    end else begin
      case (r_rx_state)
        R_IDLE: if (r_fall && !r_dat_s2) w_rx_next = R_DATA;
        R_DATA: if (r_fall && r_rx_cnt == 3'd7) w_rx_next = R_PAR;
        R_PAR:  if (r_fall) w_rx_next = R_STOP;
        R_STOP: if (r_fall) begin
          w_rx_next = R_IDLE;
          if (r_dat_s2 && (^{r_rx_shift, r_rx_par})) w_rx_push = 1'b1;
          else                                       w_rx_perr = 1'b1;
        end
        default: w_rx_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else begin
      if (r_rx_state == R_IDLE) begin
        r_rx_cnt <= '0;
      end else if (r_rx_state == R_DATA && r_fall) begin
        r_rx_shift <= {r_dat_s2, r_rx_shift[7:1]};
        r_rx_cnt   <= r_rx_cnt + 1'b1;
      end
      if (r_rx_state == R_PAR && r_fall) r_rx_par <= r_dat_s2;
    end
  end

  // RX FIFO; a pop in the same cycle makes room for the push
  assign w_do_push = w_rx_push & (~w_full | w_pop);
  assign w_set_ovf = w_rx_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tx_state <= T_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_err  = 1'b0;
    case (r_tx_state)
      T_IDLE: if (w_tx_start) w_tx_next = T_INH;
      T_INH:  if (r_inh_cnt == c_INH_LAST) w_tx_next = T_REQ;
      T_REQ:  if (r_fall) w_tx_next = T_BITS;
      T_BITS: if (r_fall && r_tx_cnt == 4'd9) w_tx_next = T_ACK;
      T_ACK:  if (r_fall) begin
        w_tx_next = T_WAIT;
        w_tx_err  = r_dat_s2;
      end
      T_WAIT: if (r_clk_filt) w_tx_next = T_IDLE;
      default: w_tx_next = T_IDLE;
    endcase
    if (w_timeout && w_tx_active) begin
      w_tx_next = T_IDLE;
      w_tx_err  = 1'b1;
    end
  end

  // Pin drivers registered from next state; shifter holds {stop, parity, data}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_t   <= 1'b1;
      r_dat_t   <= 1'b1;
      r_inh_cnt <= '0;
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_done <= 1'b0;
    end else begin
      r_clk_t <= (w_tx_next != T_INH);
      case (w_tx_next)
        T_REQ:   r_dat_t <= 1'b0;
        T_BITS:  if (r_fall) r_dat_t <= r_tx_sh[0];
        default: r_dat_t <= 1'b1;
      endcase
      if (r_tx_state == T_INH) r_inh_cnt <= r_inh_cnt + 1'b1;
      else                     r_inh_cnt <= '0;
      if (w_tx_start) begin
        r_tx_sh  <= {1'b1, ~^writedata[7:0], writedata[7:0]};
        r_tx_cnt <= '0;
      end else if (r_fall && (r_tx_state == T_REQ || r_tx_state == T_BITS)) begin
        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      if (r_tx_state != T_IDLE && w_tx_next == T_IDLE) r_tx_done <= 1'b1;
      else if (w_data_wr && r_tx_done)                 r_tx_done <= 1'b0;
    end
  end

  // Control and sticky status; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_re    <= 1'b0;
      r_perr  <= 1'b0;
      r_ovf   <= 1'b0;
      r_txerr <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_re <= writedata[0];
      r_perr  <= w_rx_perr | (r_perr  & ~(w_ctrl_wr & writedata[1]));
      r_ovf   <= w_set_ovf | (r_ovf   & ~(w_ctrl_wr & writedata[9]));
      r_txerr <= w_tx_err  | (r_txerr & ~(w_ctrl_wr & writedata[10]));
      r_irq   <= r_re & ~w_empty;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for ps2_host_fifo: a PS/2 device model drives/receives frames
// on wired-AND pins while bus tasks check registers against hand-computed values.
module tb_ps2_host_fifo;

  localparam int c_DEPTH   = 4;
  localparam int c_INH     = 50;
  localparam int c_TIMEOUT = 2000;
  localparam int c_FILTER  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] paddr;
  logic        psel, chipselect, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest_n, irq;
  logic        ps2_clk_line, ps2_dat_line;
  logic        PS2_CLK_o, PS2_DAT_o, PS2_CLK_t, PS2_DAT_t;
  logic        dev_clk = 1'b1;
  logic        dev_dat = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int inh_run  = 0;
  int inh_max  = 0;

  always #5 clk = ~clk;

  assign ps2_clk_line = dev_clk & PS2_CLK_t;
  assign ps2_dat_line = dev_dat & PS2_DAT_t;

  ps2_host_fifo #(
    .FIFO_DEPTH     (c_DEPTH),
    .INHIBIT_CYCLES (c_INH),
    .TIMEOUT_CYCLES (c_TIMEOUT),
    .FILTER_LEN     (c_FILTER)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .paddr         (paddr),
    .psel          (psel),
    .chipselect    (chipselect),
    .byteenable    (byteenable),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .waitrequest_n (waitrequest_n),
    .irq           (irq),
    .PS2_CLK_i     (ps2_clk_line),
    .PS2_DAT_i     (ps2_dat_line),
    .PS2_CLK_o     (PS2_CLK_o),
    .PS2_DAT_o     (PS2_DAT_o),
    .PS2_CLK_t     (PS2_CLK_t),
    .PS2_DAT_t     (PS2_DAT_t)
  );

  // Longest stretch the host holds PS2_CLK low
  always @(posedge clk) begin
    if (!PS2_CLK_t) begin
      inh_run <= inh_run + 1;
    end else begin
      if (inh_run > inh_max) inh_max <= inh_run;
      inh_run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic dev_bit(input logic v);
    dev_dat = v;
    repeat (10) @(posedge clk);
    dev_clk = 1'b0;
    repeat (20) @(posedge clk);
    dev_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic dev_frame(input logic [7:0] b, input logic bad_par);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b[i]);
    dev_bit((~^b) ^ bad_par);
    dev_bit(1'b1);
    dev_dat = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Device side of a host-to-device send: waits for request, clocks 11 bits
  task automatic dev_host_rx(input logic ack, output logic [9:0] bits,
                             output logic ok, output logic rts);
    ok   = 1'b1;
    bits = '0;
    for (int i = 0; i < 1000 && PS2_CLK_t; i++) @(posedge clk);
    if (PS2_CLK_t) ok = 1'b0;
    for (int i = 0; i < 5000 && !PS2_CLK_t; i++) @(posedge clk);
    if (!PS2_CLK_t) ok = 1'b0;
    repeat (5) @(posedge clk);
    rts = PS2_DAT_t;
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(posedge clk);
      bits[i] = ps2_dat_line;
      dev_clk = 1'b1;
      repeat (20) @(posedge clk);
    end
    dev_dat = ack;
    repeat (5) @(posedge clk);
    dev_clk = 1'b0;
    repeat (20) @(posedge clk);
    dev_clk = 1'b1;
    repeat (10) @(posedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic wrq);
    @(negedge clk);
    psel = 1'b1; chipselect = 1'b1; write = 1'b0; paddr = addr;
    #2;
    data = readdata;
    wrq  = waitrequest_n;
    @(posedge clk);
    #1;
    psel = 1'b0; chipselect = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        w;
    bus_read(addr, d, w);
    check_eq(tag, d, exp);
  endtask

  task automatic ctrl_write(input logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; chipselect = 1'b1; write = 1'b1; paddr = 32'h4; writedata = data;
    @(posedge clk);
    #1;
    psel = 1'b0; chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic data_write(input logic [7:0] b, output logic first_wrq, output logic done);
    @(negedge clk);
    psel = 1'b1; chipselect = 1'b1; write = 1'b1; paddr = 32'h0; writedata = {24'h0, b};
    #2;
    first_wrq = waitrequest_n;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (waitrequest_n) done = 1'b1;
      else begin
        @(negedge clk);
        #2;
      end
    end
    @(posedge clk);
    #1;
    psel = 1'b0; chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        wrq, wr_first, wr_done, dev_ok, rts;
    logic [9:0]  rx_bits;

    reset_n = 1'b0; psel = 1'b0; chipselect = 1'b0; write = 1'b0;
    paddr = '0; writedata = '0; byteenable = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_wrq", {31'h0, waitrequest_n}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_pins_t", {30'h0, PS2_CLK_t, PS2_DAT_t}, 32'h3);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_read(32'h4, rd, wrq);
    check_eq("rst_ctrl", rd, 32'h0);
    check_eq("read_wrq", {31'h0, wrq}, 32'h1);

    // Receive 0xFA
    dev_frame(8'hFA, 1'b0);
    read_check("rx_fa", 32'h0, 32'h0001_80FA);
    read_check("rx_fa_empty", 32'h0, 32'h0000_0000);

    // Send 0xEE with ACK=0
    fork
      data_write(8'hEE, wr_first, wr_done);
      dev_host_rx(1'b0, rx_bits, dev_ok, rts);
    join
    check_eq("tx_wrq_first", {31'h0, wr_first}, 32'h0);
    check_eq("tx_done", {31'h0, wr_done}, 32'h1);
    check_eq("tx_dev_ok", {31'h0, dev_ok}, 32'h1);
    check_eq("tx_rts_dat", {31'h0, rts}, 32'h0);
    check_eq("tx_bits", {22'h0, rx_bits}, 32'h0000_03EE);
    check_eq("tx_inhibit", {31'h0, inh_max >= c_INH}, 32'h1);
    read_check("tx_ctrl", 32'h4, 32'h0);

    // Parity error then W1C
    dev_frame(8'h55, 1'b1);
    read_check("perr_data", 32'h0, 32'h0);
    read_check("perr_ctrl", 32'h4, 32'h0000_0002);
    ctrl_write(32'h2);
    read_check("perr_clr", 32'h4, 32'h0);

    // Overflow with a 4-deep FIFO
    for (int i = 1; i <= 5; i++) dev_frame(8'(i), 1'b0);
    read_check("ovf_ctrl", 32'h4, 32'h0000_0300);
    read_check("ovf_rd1", 32'h0, 32'h0004_8001);
    read_check("ovf_rd2", 32'h0, 32'h0003_8002);
    read_check("ovf_rd3", 32'h0, 32'h0002_8003);
    read_check("ovf_rd4", 32'h0, 32'h0001_8004);
    read_check("ovf_rd5", 32'h0, 32'h0);
    ctrl_write(32'h200);
    read_check("ovf_clr", 32'h4, 32'h0);

    // Truncated frame, timeout, then a clean 0x1C
    dev_bit(1'b0); dev_bit(1'b0); dev_bit(1'b0); dev_bit(1'b1);
    repeat (c_TIMEOUT + 100) @(posedge clk);
    read_check("to_ctrl", 32'h4, 32'h0);
    dev_frame(8'h1C, 1'b0);
    read_check("to_rx_1c", 32'h0, 32'h0001_801C);

    // Interrupt
    ctrl_write(32'h1);
    dev_frame(8'h5A, 1'b0);
    #1;
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    read_check("irq_rd", 32'h0, 32'h0001_805A);
    check_eq("irq_lag", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
    ctrl_write(32'h0);

    // Reset while inhibiting a send
    @(negedge clk);
    psel = 1'b1; chipselect = 1'b1; write = 1'b1; paddr = 32'h0; writedata = 32'h12;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mid_inh_clk", {31'h0, PS2_CLK_t}, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_pins", {30'h0, PS2_CLK_t, PS2_DAT_t}, 32'h3);
    psel = 1'b0; chipselect = 1'b0; write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    read_check("mid_rst_ctrl", 32'h4, 32'h0);
    read_check("mid_rst_data", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
